// File: rtl/load_store_pkg.sv
// Shared decode constants and helpers for the RV32I load/store sequencer.
package load_store_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Response fault codes
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Stores have no unsigned variants; loads allow B/H/W/BU/HU.
  function automatic logic f3_legal(logic [2:0] f3, logic is_store);
    if (is_store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Only meaningful for legal funct3: f3[1:0] gives the access size.
  function automatic logic f3_misaligned(logic [2:0] f3, logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] store_strobe(logic [2:0] f3, logic [1:0] off);
    logic [3:0] strb;
    unique case (f3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate the LSB-justified source so every lane the strobe selects holds it.
  function automatic logic [31:0] store_wdata(logic [2:0] f3, logic [31:0] sd);
    logic [31:0] wd;
    unique case (f3[1:0])
      2'b00:   wd = {4{sd[7:0]}};
      2'b01:   wd = {2{sd[15:0]}};
      default: wd = sd;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a read word for a load.
module load_extend
  import load_store_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Bring the addressed byte lane down to bit 0, then extend per funct3
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    unique case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Sequences RV32I loads/stores from execute to the data-memory port.
module load_store_sequencer
  import load_store_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              store_q, store_d;
  logic [1:0]        off_q, off_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_fault_q, rsp_fault_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [2:0]        in_f3;
  logic              in_store;
  logic [31:0]       ext_data;

  // Only funct3 and the store bit of the instruction matter here
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[31:15], instruction[11:6], instruction[4:0]};

  assign in_f3    = instruction[14:12];
  assign in_store = instruction[5];

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  // Next-state and registered-output computation for the IDLE/REQ/RESP sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    store_d     = store_q;
    off_d       = off_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        // req_ready_q gates acceptance so the post-RESP bubble cycle takes nothing
        if (req_valid && req_ready_q) begin
          funct3_d    = in_f3;
          store_d     = in_store;
          off_d       = addr[1:0];
          cnt_d       = '0;
          rsp_data_d  = '0;
          req_ready_d = 1'b0;
          if (!f3_legal(in_f3, in_store)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = FLT_ILLEGAL;
          end else if (f3_misaligned(in_f3, addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = FLT_MISALIGN;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = in_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = in_store ? store_strobe(in_f3, addr[1:0]) : 4'b0000;
            mem_wdata_d = in_store ? store_wdata(in_f3, store_data) : 32'h0;
          end
        end
      end

      ST_REQ: begin
        // An ack on the final counted cycle still completes normally
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_fault_d = FLT_NONE;
          rsp_data_d  = store_q ? 32'h0 : ext_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_fault_d = FLT_TIMEOUT;
          rsp_data_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = 32'h0;
          rsp_fault_d = FLT_NONE;
          cnt_d       = '0;
          req_ready_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        mem_req_d   = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      funct3_q    <= 3'b000;
      store_q     <= 1'b0;
      off_q       <= 2'b00;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_fault_q <= FLT_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      off_q       <= off_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Randomized bench for load_store_sequencer with a behavioural reference model.
module tb_load_store_sequencer;

  localparam int Timeout = 16;
  localparam int Never   = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] instruction = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  load_store_sequencer #(
    .TIMEOUT_CYCLES (Timeout),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .instruction (instruction),
    .addr        (addr),
    .store_data  (store_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_fault   (rsp_fault),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int unsigned acc_bytes(input logic [2:0] f3);
    if (f3 == 3'd2) return 4;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 1;
  endfunction

  function automatic logic [1:0] model_fault(input logic [2:0] f3, input logic st,
                                             input logic [31:0] a);
    int unsigned nb;
    bit legal;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 2'b10;
    nb = acc_bytes(f3);
    if ((a % nb) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint unsigned v, span;
    int unsigned nb;
    nb   = acc_bytes(f3);
    span = 64'd1 << (8 * nb);
    v    = ({32'h0, rd} >> (8 * (a % 4))) % span;
    if (f3 < 3'd4 && nb < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s;
    s = ((1 << acc_bytes(f3)) - 1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    longint unsigned v;
    int unsigned nb;
    nb = acc_bytes(f3);
    if (nb == 1) v = ({32'h0, sd} % 256) * 64'h0101_0101;
    else if (nb == 2) v = ({32'h0, sd} % 65536) * 64'h0001_0001;
    else v = {32'h0, sd};
    return v[31:0];
  endfunction

  // ---------------- one complete operation ----------------
  // Called just after a negedge. ack_at = REQ cycle index carrying mem_ack (Never = no ack).
  task automatic do_op(input string nm, input logic [2:0] f3, input logic st,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int ack_at, input int hold);
    logic [1:0]  efault;
    logic [31:0] edata;
    logic [31:0] instr;
    int          waited, highs;
    bit          acked, req_ok, hold_ok;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_eq({nm, "_ready_wait"}, 32'(req_ready), 32'd1);
    instr        = $urandom;
    instr[14:12] = f3;
    instr[5]     = st;
    req_valid    = 1'b1;
    instruction  = instr;
    addr         = a;
    store_data   = sd;
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    instruction  = $urandom;
    addr         = $urandom;
    store_data   = $urandom;
    efault       = model_fault(f3, st, a);
    edata        = 32'h0;
    if (efault != 2'b00) begin
      check_eq({nm, "_fault_no_memreq"}, 32'(mem_req), 32'd0);
      check_eq({nm, "_fault_rsp_valid"}, 32'(rsp_valid), 32'd1);
    end else begin
      acked  = 1'b0;
      req_ok = 1'b1;
      highs  = 0;
      for (int n = 0; n < Timeout; n++) begin
        highs++;
        if (!(mem_req === 1'b1 && rsp_valid === 1'b0)) req_ok = 1'b0;
        if (n == 0) begin
          check_eq({nm, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
          check_eq({nm, "_mem_we"}, 32'(mem_we), 32'(st));
          check_eq({nm, "_mem_wstrb"}, 32'(mem_wstrb), st ? 32'(model_strb(f3, a)) : 32'd0);
          if (st) check_eq({nm, "_mem_wdata"}, mem_wdata, model_wdata(f3, sd));
        end
        if (n == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
          @(posedge clk);
          @(negedge clk);
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          acked     = 1'b1;
          break;
        end
        @(posedge clk);
        @(negedge clk);
      end
      check_eq({nm, "_req_phase"}, 32'(req_ok), 32'd1);
      check_eq({nm, "_req_cycles"}, highs, acked ? ack_at + 1 : Timeout);
      check_eq({nm, "_memreq_drop"}, 32'(mem_req), 32'd0);
      check_eq({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      if (!acked) efault = 2'b11;
      else if (!st) edata = model_load(f3, a, rd);
    end
    check_eq({nm, "_rsp_fault"}, 32'(rsp_fault), 32'(efault));
    check_eq({nm, "_rsp_data"}, rsp_data, edata);
    // Hold the response; a request presented now must be ignored
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      req_valid   = 1'b1;
      instruction = 32'h0000_2023;
      @(posedge clk);
      @(negedge clk);
      if (!(rsp_valid === 1'b1 && rsp_data === edata && rsp_fault === efault &&
            req_ready === 1'b0 && mem_req === 1'b0)) hold_ok = 1'b0;
    end
    req_valid = 1'b0;
    if (hold > 0) check_eq({nm, "_hold_stable"}, 32'(hold_ok), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({nm, "_rsp_clear"}, {30'h0, rsp_valid, req_ready}, 32'd0);
    @(negedge clk);
    check_eq({nm, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit quiet_ok;
    // Reset values
    #12;
    check_eq("rst_outputs", {rsp_data | mem_addr | mem_wdata},
             32'h0);
    check_eq("rst_ctrl", {25'h0, req_ready, rsp_valid, rsp_fault, mem_req, mem_we, 1'b0},
             32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("rel_ready_high", 32'(req_ready), 32'd1);

    // Directed cases
    do_op("lb",       3'b000, 1'b0, 32'h103, 32'h0,        32'h80AABBCC, 2, 0);
    do_op("sh",       3'b001, 1'b1, 32'h202, 32'h1234ABCD, 32'h0,        0, 0);
    do_op("lw_mis",   3'b010, 1'b0, 32'h301, 32'h0,        32'h0,        0, 2);
    do_op("ill",      3'b110, 1'b0, 32'h300, 32'h0,        32'h0,        0, 0);
    do_op("ill_pri",  3'b110, 1'b0, 32'h301, 32'h0,        32'h0,        0, 0);
    do_op("lhu_tmo",  3'b101, 1'b0, 32'h402, 32'h0,        32'h0,        Never, 0);
    do_op("lhu_late", 3'b101, 1'b0, 32'h402, 32'h0,        32'h8001_0000, Timeout - 1, 0);
    do_op("lbu_hold", 3'b100, 1'b0, 32'h00F, 32'h0,        32'hF0123456, 0, 5);

    // Reset in the middle of REQ
    req_valid   = 1'b1;
    instruction = 32'h0000_2003;
    addr        = 32'h500;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", {29'h0, mem_req, rsp_valid, req_ready}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack  = 1'b0;
    quiet_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0) quiet_ok = 1'b0;
      @(negedge clk);
    end
    check_eq("late_ack_ignored", 32'(quiet_ok), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      int r, ack_at;
      r = $urandom_range(0, 9);
      if (r <= 5) ack_at = r;
      else if (r == 6) ack_at = Timeout - 1;
      else if (r == 7) ack_at = Never;
      else ack_at = 1;
      do_op($sformatf("rnd%0d", k), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, ack_at, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
